// File: rtl/fp_add_scheduler_pkg.sv
// Shared types and constants for the fp32 adder scheduling block.
package fp_add_scheduler_pkg;

  localparam int unsigned FP_W     = 32;
  // Tag id sized for the largest supported requester count (8).
  localparam int unsigned TAG_ID_W = 3;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2,
    ST_HOLD  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/fp_add_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts one past the pointer and wraps.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt_c,
  output logic [IDX_W-1:0] gnt_idx_c,
  output logic             gnt_any_c
);

  logic [IDX_W-1:0] cand;

  // First requester found walking ptr+1, ptr+2, ... modulo N_REQ wins.
  always_comb begin
    gnt_c     = '0;
    gnt_idx_c = '0;
    gnt_any_c = 1'b0;
    cand      = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = IDX_W'((32'(ptr) + i) % N_REQ);
      if (!gnt_any_c && req[cand]) begin
        gnt_c[cand] = 1'b1;
        gnt_idx_c   = cand;
        gnt_any_c   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_add_scheduler.sv
// Shares one pipelined fp32 adder among N_REQ requesters, tags results with
// the requester id and supports a drain handshake to empty the pipeline.
module fp_add_scheduler
  import fp_add_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ADD_LAT = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*FP_W-1:0]    req_a,
  input  logic [N_REQ*FP_W-1:0]    req_b,
  output logic [N_REQ-1:0]         req_ready,
  output logic [FP_W-1:0]          add_a,
  output logic [FP_W-1:0]          add_b,
  input  logic [FP_W-1:0]          add_result,
  output logic                     resp_valid,
  output logic [$clog2(N_REQ)-1:0] resp_id,
  output logic [FP_W-1:0]          resp_data,
  input  logic                     drain,
  output logic                     drain_done,
  output logic                     busy
);

  localparam int unsigned ID_W      = $clog2(N_REQ);
  localparam int unsigned TAG_DEPTH = ADD_LAT + 1;

  sched_state_e    state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  tag_t            tag_q [TAG_DEPTH];
  tag_t            tag_d [TAG_DEPTH];
  logic [FP_W-1:0] add_a_q, add_a_d, add_b_q, add_b_d;
  logic [FP_W-1:0] resp_data_q, resp_data_d;
  logic [ID_W-1:0] resp_id_q, resp_id_d;
  logic            resp_valid_q, resp_valid_d;
  logic            drain_done_q, drain_done_d;
  logic            busy_q, busy_d;

  logic [N_REQ-1:0] arb_gnt_c;
  logic [ID_W-1:0]  arb_idx_c;
  logic             arb_any_c;
  logic             issue_en_c;
  logic             xfer_c;
  logic             tags_live_c;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .gnt_c     (arb_gnt_c),
    .gnt_idx_c (arb_idx_c),
    .gnt_any_c (arb_any_c)
  );

  // Grants only in RUN with no drain request and not in reset.
  always_comb begin
    issue_en_c = (state_q == ST_RUN) && !drain && !rst;
    req_ready  = issue_en_c ? arb_gnt_c : '0;
    xfer_c     = issue_en_c && arb_any_c;
  end

  // Any issued operation still travelling through the tag pipeline.
  always_comb begin
    tags_live_c = 1'b0;
    for (int unsigned k = 0; k < TAG_DEPTH; k++) begin
      tags_live_c = tags_live_c | tag_q[k].valid;
    end
  end

  // Operand issue, tag shift, response capture and busy tracking.
  always_comb begin
    ptr_d   = xfer_c ? arb_idx_c : ptr_q;
    add_a_d = '0;
    add_b_d = '0;
    if (xfer_c) begin
      add_a_d = req_a[32'(arb_idx_c)*FP_W +: FP_W];
      add_b_d = req_b[32'(arb_idx_c)*FP_W +: FP_W];
    end
    tag_d[0].valid = xfer_c;
    tag_d[0].id    = TAG_ID_W'(arb_idx_c);
    for (int unsigned k = 1; k < TAG_DEPTH; k++) begin
      tag_d[k] = tag_q[k-1];
    end
    resp_valid_d = tag_q[ADD_LAT].valid;
    resp_id_d    = ID_W'(tag_q[ADD_LAT].id);
    resp_data_d  = tag_q[ADD_LAT].valid ? add_result : resp_data_q;
    busy_d       = resp_valid_d;
    for (int unsigned k = 0; k < TAG_DEPTH; k++) begin
      busy_d = busy_d | tag_d[k].valid;
    end
  end

  // Drain sequencing; drain_done is raised on the edge entering DONE.
  always_comb begin
    state_d      = state_q;
    drain_done_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (drain) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!tags_live_c && !resp_valid_q) begin
          state_d      = ST_DONE;
          drain_done_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = drain ? ST_HOLD : ST_RUN;
      end
      ST_HOLD: begin
        if (!drain) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      ptr_q        <= ID_W'(N_REQ - 1);
      add_a_q      <= '0;
      add_b_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      drain_done_q <= 1'b0;
      busy_q       <= 1'b0;
      for (int unsigned k = 0; k < TAG_DEPTH; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      add_a_q      <= add_a_d;
      add_b_q      <= add_b_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      drain_done_q <= drain_done_d;
      busy_q       <= busy_d;
      for (int unsigned k = 0; k < TAG_DEPTH; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign drain_done = drain_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Bench for fp_add_scheduler with a behavioural 5-stage fp32 adder.
module tb_fp_add_scheduler;

  localparam int N_REQ   = 4;
  localparam int ADD_LAT = 5;
  localparam int RESP_LAT = ADD_LAT + 2;

  logic               clk;
  logic               rst;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*32-1:0] req_a;
  logic [N_REQ*32-1:0] req_b;
  logic [N_REQ-1:0]   req_ready;
  logic [31:0]        add_a;
  logic [31:0]        add_b;
  logic [31:0]        add_result;
  logic               resp_valid;
  logic [1:0]         resp_id;
  logic [31:0]        resp_data;
  logic               drain;
  logic               drain_done;
  logic               busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int op_seq   = 0;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    int          due;
  } sb_t;
  sb_t sb_q [$];

  typedef struct {
    logic [3:0] vld;
    logic [3:0] rdy;
  } vec_t;
  vec_t vecs [18];

  fp_add_scheduler #(.N_REQ(N_REQ), .ADD_LAT(ADD_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_result (add_result),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .drain      (drain),
    .drain_done (drain_done),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    int e;
    if (f[30:0] == 31'd0) return 0.0;
    e = int'(f[30:23]) - 127 + 1023;
    d = {f[31], 11'(e), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] fp_add_model(input logic [31:0] a, input logic [31:0] b);
    real s;
    logic [63:0] d;
    int e;
    s = f2r(a) + f2r(b);
    d = $realtobits(s);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], 8'(e), d[51:29]};
  endfunction

  // Shared adder: ADD_LAT register stages behind the operand registers.
  logic [31:0] add_pipe [ADD_LAT];
  always @(posedge clk) begin
    add_pipe[0] <= fp_add_model(add_a, add_b);
    for (int k = 1; k < ADD_LAT; k++) add_pipe[k] <= add_pipe[k-1];
  end
  assign add_result = add_pipe[ADD_LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Response scoreboard: every response must match the oldest expectation
  // in id, data and arrival cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL resp_unexpected: got id=%0d data=%h, expected no response (cycle %0d)",
                   resp_id, resp_data, cyc);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          chk("resp_cycle", 32'(cyc), 32'(e.due));
          chk("resp_id", 32'(resp_id), 32'(e.id));
          chk("resp_data", resp_data, e.data);
        end
      end else if (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
        sb_t e;
        e = sb_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL resp_missing: got none, expected id=%0d data=%h at cycle %0d", e.id, e.data, e.due);
      end
    end
  end

  // One clock of stimulus with grant/drain_done/busy checks; -1 skips a check.
  task automatic run_cycle(input logic [3:0] vld, input logic drn, input logic [3:0] exp_rdy,
                           input int exp_dd, input int exp_busy);
    logic [31:0] a_s [4];
    logic [31:0] b_s [4];
    sb_t e;
    for (int s = 0; s < 4; s++) begin
      a_s[s] = 32'h3F80_0000 + (32'(op_seq) << 12) + (32'(s) << 20);
      b_s[s] = 32'h4000_0000 + (32'(op_seq) << 11) + (32'(s) << 19);
      req_a[s*32 +: 32] = a_s[s];
      req_b[s*32 +: 32] = b_s[s];
    end
    op_seq++;
    req_valid = vld;
    drain     = drn;
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (exp_dd >= 0) chk("drain_done", 32'(drain_done), 32'(exp_dd));
    if (exp_busy >= 0) chk("busy", 32'(busy), 32'(exp_busy));
    for (int s = 0; s < 4; s++) begin
      if (exp_rdy[s]) begin
        e.id   = 2'(s);
        e.data = fp_add_model(a_s[s], b_s[s]);
        e.due  = cyc + RESP_LAT;
        sb_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    req_valid = '0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    drain     = 1'b0;
    req_valid = 4'b1111;
    sb_q.delete();
    repeat (2) begin
      @(negedge clk);
      chk("ready_in_reset", 32'(req_ready), 32'h0);
    end
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("rst_add_a", add_a, 32'h0);
    chk("rst_add_b", add_b, 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_id", 32'(resp_id), 32'h0);
    chk("rst_resp_data", resp_data, 32'h0);
    chk("rst_drain_done", 32'(drain_done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sb_empty();
    for (int k = 0; k < 40 && sb_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_outstanding: got %0d pending responses, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected end within 100000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c2;
    int d;
    vecs = '{
      '{4'b1111, 4'b0001}, '{4'b1111, 4'b0010}, '{4'b1111, 4'b0100}, '{4'b1111, 4'b1000},
      '{4'b1111, 4'b0001}, '{4'b1111, 4'b0010}, '{4'b1111, 4'b0100}, '{4'b1111, 4'b1000},
      '{4'b0010, 4'b0010}, '{4'b1010, 4'b1000}, '{4'b1010, 4'b0010}, '{4'b0000, 4'b0000},
      '{4'b1111, 4'b0100}, '{4'b0101, 4'b0001}, '{4'b0101, 4'b0100}, '{4'b0000, 4'b0000},
      '{4'b1000, 4'b1000}, '{4'b0000, 4'b0000}
    };
    rst       = 1'b1;
    drain     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;

    do_reset();

    // 1.0 + 2.0 from requester 0.
    begin
      sb_t e;
      req_a     = {96'h0, 32'h3F80_0000};
      req_b     = {96'h0, 32'h4000_0000};
      req_valid = 4'b0001;
      @(negedge clk);
      chk("single_ready", 32'(req_ready), 32'h1);
      e.id   = 2'd0;
      e.data = 32'h4040_0000;
      e.due  = cyc + RESP_LAT;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      req_valid = '0;
    end
    wait_sb_empty();

    // Round-robin vectors from a fresh pointer.
    do_reset();
    for (int i = 0; i < 18; i++) run_cycle(vecs[i].vld, 1'b0, vecs[i].rdy, 0, -1);
    wait_sb_empty();

    // Three transfers, then drain while all requesters keep asking.
    run_cycle(4'b0111, 1'b0, 4'b0001, 0, -1);
    run_cycle(4'b0111, 1'b0, 4'b0010, 0, -1);
    run_cycle(4'b0111, 1'b0, 4'b0100, 0, -1);
    c2 = cyc - 1;
    for (int k = 0; k < 14; k++) begin
      run_cycle(4'b1111, 1'b1, 4'b0000, (cyc == c2 + RESP_LAT + 2) ? 1 : 0,
                (cyc <= c2 + RESP_LAT) ? 1 : 0);
    end
    run_cycle(4'b0000, 1'b0, 4'b0000, 0, 0);
    run_cycle(4'b1111, 1'b0, 4'b1000, 0, 0);
    wait_sb_empty();

    // Drain on an empty pipeline held for ten cycles.
    d = cyc;
    for (int k = 0; k < 10; k++) run_cycle(4'b1111, 1'b1, 4'b0000, (cyc == d + 2) ? 1 : 0, 0);
    run_cycle(4'b1111, 1'b0, 4'b0000, 0, 0);
    run_cycle(4'b1111, 1'b0, 4'b0001, 0, 0);
    wait_sb_empty();

    // Reset two cycles after a transfer discards it.
    run_cycle(4'b0010, 1'b0, 4'b0010, -1, -1);
    run_cycle(4'b0000, 1'b0, 4'b0000, -1, -1);
    do_reset();
    for (int k = 0; k < 10; k++) begin
      run_cycle(4'b0000, 1'b0, 4'b0000, 0, 0);
      chk("post_rst_resp_valid", 32'(resp_valid), 32'h0);
    end
    run_cycle(4'b1111, 1'b0, 4'b0001, 0, 0);
    wait_sb_empty();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
